// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: length header, big-endian program words, XOR checksum.
// Holds the core in reset until a load completes with a good checksum.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for first start, core held
  // S_LEN_HI | expecting word-count high byte
  // S_LEN_LO | expecting word-count low byte, length checked here
  // S_DATA   | assembling program words, one write per 4 bytes
  // S_CHECK  | expecting checksum byte
  // S_DONE   | load good, core released
  // S_ERROR  | load aborted, core held
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t      state;
  logic [15:0] len;
  logic [23:0] shift;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic        xfer;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      word_cnt  <= '0;
      len       <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_LEN_HI;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            word_cnt <= '0;
            csum     <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            if ({1'b0, len[15:8], in_data} > CAPACITY) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if ({len[15:8], in_data} == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {shift, in_data};
              mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              word_cnt  <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == len) state <= S_CHECK;
            end else begin
              shift <= {shift[15:0], in_data};
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream vector table plus hand-written multi-cycle sequences.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [15:0]   word_cnt;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           nbytes;
    logic [127:0] bytes;    // stream, first byte in the top 8 bits
    logic         exp_done;
    logic         exp_err;
    logic [15:0]  exp_wc;
    int           exp_wr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t vecs [6];

  int n_vec = 0;
  int n_fail = 0;

  // Write monitor: captures memory and counts out-of-order or repeated strobes.
  logic [31:0] mem [0:255];
  int tot_wr = 0;
  int base = 0;
  int bad_seq = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_addr !== AW'(tot_wr - base) || word_cnt !== 16'(tot_wr - base + 1))
        bad_seq <= bad_seq + 1;
      mem[mem_addr] <= mem_wdata;
      tot_wr <= tot_wr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic load(input vec_t v, input bit gap, input bit with_start, input string tag);
    base = tot_wr;
    if (with_start) pulse_start();
    for (int k = 0; k < v.nbytes; k++) send_byte(v.bytes[127-8*k -: 8], gap);
    end_stream();
    wait_end();
    chk({tag, "_done"},     32'(done),          32'(v.exp_done));
    chk({tag, "_error"},    32'(error),         32'(v.exp_err));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold),      32'(!v.exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready),      32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt),      32'(v.exp_wc));
    chk({tag, "_writes"},   32'(tot_wr - base), 32'(v.exp_wr));
    chk({tag, "_wr_order"}, 32'(bad_seq),       32'd0);
    if (v.exp_wr >= 1) chk({tag, "_mem0"}, mem[0], v.w0);
    if (v.exp_wr >= 2) chk({tag, "_mem1"}, mem[1], v.w1);
  endtask

  initial begin
    logic [7:0] cs;
    logic [31:0] w;

    vecs[0] = '{11, {88'h0002200800050108402044, 40'h0}, 1'b1, 1'b0, 16'd2, 2, 32'h20080005, 32'h01084020};
    vecs[1] = '{11, {88'h0002200800050108402045, 40'h0}, 1'b0, 1'b1, 16'd2, 2, 32'h20080005, 32'h01084020};
    vecs[2] = '{2,  {16'h0101, 112'h0},                  1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0};
    vecs[3] = '{3,  {24'h000000, 104'h0},                1'b1, 1'b0, 16'd0, 0, 32'h0, 32'h0};
    vecs[4] = '{3,  {24'h000001, 104'h0},                1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0};
    vecs[5] = '{7,  {56'h0001DEADBEEF22, 72'h0},         1'b1, 1'b0, 16'd1, 1, 32'hDEADBEEF, 32'h0};

    // Reset values
    #12;
    chk("rst_cpu_hold",  32'(cpu_hold),  32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_error",     32'(error),     32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start and first byte together in IDLE: byte must wait for LEN_HI
    base = tot_wr;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("lenhi_in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k < vecs[0].nbytes; k++) send_byte(vecs[0].bytes[127-8*k -: 8], 1'b0);
    end_stream();
    wait_end();
    chk("idle_start_done",     32'(done),     32'd1);
    chk("idle_start_word_cnt", 32'(word_cnt), 32'd2);
    chk("idle_start_mem1",     mem[1],        32'h01084020);

    for (int i = 0; i < 6; i++) load(vecs[i], 1'b0, 1'b1, $sformatf("vec%0d", i));

    // in_valid toggling every other cycle
    load(vecs[0], 1'b1, 1'b1, "gap");

    // restart from DONE, second load overwrites address 0
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart_done",     32'(done),     32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    load(vecs[5], 1'b0, 1'b0, "reload");

    // N == capacity fills memory exactly
    base = tot_wr;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'(i * 7 + 1)};
      for (int k = 3; k >= 0; k--) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], 1'b0);
      end
    end
    send_byte(cs, 1'b0);
    end_stream();
    wait_end();
    chk("full_done",     32'(done),          32'd1);
    chk("full_word_cnt", 32'(word_cnt),      32'd256);
    chk("full_writes",   32'(tot_wr - base), 32'd256);
    chk("full_wr_order", 32'(bad_seq),       32'd0);
    chk("full_mem255",   mem[255],           {8'hFF, 8'h00, 8'hA5, 8'(255 * 7 + 1)});

    // async reset in the middle of DATA
    base = tot_wr;
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(vecs[0].bytes[127-8*k -: 8], 1'b0);
    #2;
    chk("mid_word_cnt", 32'(word_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mem_we",   32'(mem_we),   32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
